// File: rtl/mem_tile_banked_sram_pkg.sv
// Shared sizing defaults and helpers for the banked SRAM memory tile.
// No ports. It holds the default parameter values and idx_width(), which
// returns the width of an index into n entries. That width is at least 1, so
// a field with a single entry still gets a legal one-bit vector.
package mem_tile_banked_sram_pkg;

  localparam int unsigned DefNumPorts     = 2;
  localparam int unsigned DefDataWidth    = 64;
  localparam int unsigned DefNumBanks     = 4;
  localparam int unsigned DefNumBankRows  = 2;
  localparam int unsigned DefSramNumWords = 512;
  localparam int unsigned DefSramLatency  = 1;
  localparam int unsigned DefRspDepth     = 2;
  localparam int unsigned DefAddrWidth    = 48;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_tile_sram_port_rsp.sv
// Response path for one requester port.
// Ports:
//   clk_i, rst_ni                 clock and asynchronous active-low reset
//   gnt_i, we_i, err_i            this port's request was accepted this cycle, plus its kind
//   bank_i, row_i                 the macro the accepted request addressed
//   mac_rdata_i                   read data of every macro, indexed bank*NumBankRows+row
//   rvalid_o, rready_i            response handshake
//   rdata_o, err_o                response payload
//   credit_ok_o                   the port may accept another request
// A tag pipeline that is SramLatency deep follows each grant. When the tag
// reaches its last stage, the addressed macro's read data is valid. The result
// goes into a fall-through FIFO. The credit counter limits outstanding requests
// to RspDepth, so the FIFO cannot overflow.
module mem_tile_sram_port_rsp
  import mem_tile_banked_sram_pkg::*;
#(
  parameter int unsigned DataWidth   = DefDataWidth,
  parameter int unsigned NumBanks    = DefNumBanks,
  parameter int unsigned NumBankRows = DefNumBankRows,
  parameter int unsigned SramLatency = DefSramLatency,
  parameter int unsigned RspDepth    = DefRspDepth,
  parameter int unsigned BankIdxW    = idx_width(NumBanks),
  parameter int unsigned RowIdxW     = idx_width(NumBankRows)
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic                                          gnt_i,
  input  logic                                          we_i,
  input  logic                                          err_i,
  input  logic [BankIdxW-1:0]                           bank_i,
  input  logic [RowIdxW-1:0]                            row_i,
  input  logic [NumBanks*NumBankRows-1:0][DataWidth-1:0] mac_rdata_i,
  output logic                                          rvalid_o,
  input  logic                                          rready_i,
  output logic [DataWidth-1:0]                          rdata_o,
  output logic                                          err_o,
  output logic                                          credit_ok_o
);

  localparam int unsigned Last    = SramLatency - 1;
  localparam int unsigned MacIdxW = idx_width(NumBanks * NumBankRows);
  localparam int unsigned CntW    = $clog2(RspDepth + 1);
  localparam int unsigned PtrW    = idx_width(RspDepth);

  logic [SramLatency-1:0] tag_valid_q, tag_we_q, tag_err_q;
  logic [BankIdxW-1:0]    tag_bank_q [SramLatency];
  logic [RowIdxW-1:0]     tag_row_q  [SramLatency];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_valid_q <= '0;
      tag_we_q    <= '0;
      tag_err_q   <= '0;
      for (int s = 0; s < SramLatency; s++) begin
        tag_bank_q[s] <= '0;
        tag_row_q[s]  <= '0;
      end
    end else begin
      tag_valid_q[0] <= gnt_i;
      tag_we_q[0]    <= we_i;
      tag_err_q[0]   <= err_i;
      tag_bank_q[0]  <= bank_i;
      tag_row_q[0]   <= row_i;
      for (int s = 1; s < SramLatency; s++) begin
        tag_valid_q[s] <= tag_valid_q[s-1];
        tag_we_q[s]    <= tag_we_q[s-1];
        tag_err_q[s]   <= tag_err_q[s-1];
        tag_bank_q[s]  <= tag_bank_q[s-1];
        tag_row_q[s]   <= tag_row_q[s-1];
      end
    end
  end

  logic                 push, push_err;
  logic [MacIdxW-1:0]   push_sel;
  logic [DataWidth-1:0] push_data;

  // Writes and out-of-range requests return zero data. Only reads show the macro output.
  always_comb begin
    push      = tag_valid_q[Last];
    push_err  = tag_err_q[Last];
    push_sel  = MacIdxW'(int'(tag_bank_q[Last]) * NumBankRows + int'(tag_row_q[Last]));
    push_data = (tag_we_q[Last] || tag_err_q[Last]) ? '0 : mac_rdata_i[push_sel];
  end

  logic [DataWidth-1:0] fifo_data_q [RspDepth];
  logic                 fifo_err_q  [RspDepth];
  logic [PtrW-1:0]      rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]      cnt_q, credit_q;
  logic                 empty, pop, store, drain;

  // Fall-through: when the FIFO is empty, the result that arrives this cycle is
  // presented directly. It is stored only if it is not consumed at once.
  always_comb begin
    empty    = (cnt_q == '0);
    rvalid_o = push || !empty;
    rdata_o  = '0;
    err_o    = 1'b0;
    if (!empty) begin
      rdata_o = fifo_data_q[rd_ptr_q];
      err_o   = fifo_err_q[rd_ptr_q];
    end else if (push) begin
      rdata_o = push_data;
      err_o   = push_err;
    end
    pop   = rvalid_o && rready_i;
    store = push && !(empty && pop);
    drain = pop && !empty;
  end

  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(RspDepth - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      credit_q <= '0;
      for (int i = 0; i < RspDepth; i++) begin
        fifo_data_q[i] <= '0;
        fifo_err_q[i]  <= 1'b0;
      end
    end else begin
      if (store) begin
        fifo_data_q[wr_ptr_q] <= push_data;
        fifo_err_q[wr_ptr_q]  <= push_err;
        wr_ptr_q              <= ptr_next(wr_ptr_q);
      end
      if (drain) rd_ptr_q <= ptr_next(rd_ptr_q);
      cnt_q    <= cnt_q + CntW'(store) - CntW'(drain);
      credit_q <= credit_q + CntW'(gnt_i) - CntW'(pop);
    end
  end

  assign credit_ok_o = (credit_q < CntW'(RspDepth));

endmodule

// File: rtl/mem_tile_banked_sram.sv
// Multi-port, word-interleaved, banked SRAM tile.
// Ports (every per-port signal is an array of NumPorts entries):
//   clk_i, rst_ni                     clock and asynchronous active-low reset
//   req_i, gnt_o                      request and acceptance (gnt_o is combinational)
//   we_i, addr_i, wdata_i, be_i       request payload (addr_i is a byte address)
//   rvalid_o, rready_i                response handshake
//   rdata_o, err_o                    response data and out-of-range flag
// Handshakes: a request transfers in a cycle where req_i[p] and gnt_o[p] are
// both high. The requester keeps the request unchanged until that cycle. A
// response transfers in a cycle where rvalid_o[p] and rready_i[p] are both
// high. rvalid_o and its payload stay constant until that cycle. Responses
// on a port come back in the order their requests were granted.
// Address decode, LSB first: byte offset | bank | word | row | range check.
module mem_tile_banked_sram
  import mem_tile_banked_sram_pkg::*;
#(
  parameter int unsigned NumPorts     = DefNumPorts,
  parameter int unsigned DataWidth    = DefDataWidth,
  parameter int unsigned NumBanks     = DefNumBanks,
  parameter int unsigned NumBankRows  = DefNumBankRows,
  parameter int unsigned SramNumWords = DefSramNumWords,
  parameter int unsigned SramLatency  = DefSramLatency,
  parameter int unsigned RspDepth     = DefRspDepth,
  parameter int unsigned AddrWidth    = DefAddrWidth
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumPorts-1:0]    req_i,
  output logic [NumPorts-1:0]    gnt_o,
  input  logic                   we_i     [NumPorts],
  input  logic [AddrWidth-1:0]   addr_i   [NumPorts],
  input  logic [DataWidth-1:0]   wdata_i  [NumPorts],
  input  logic [DataWidth/8-1:0] be_i     [NumPorts],
  output logic                   rvalid_o [NumPorts],
  input  logic                   rready_i [NumPorts],
  output logic [DataWidth-1:0]   rdata_o  [NumPorts],
  output logic                   err_o    [NumPorts]
);

  localparam int unsigned NumBytes  = DataWidth / 8;
  localparam int unsigned NumMacros = NumBanks * NumBankRows;
  localparam int unsigned BankLsb   = $clog2(NumBytes);
  localparam int unsigned WordLsb   = BankLsb + $clog2(NumBanks);
  localparam int unsigned RowLsb    = WordLsb + $clog2(SramNumWords);
  localparam int unsigned RangeLsb  = RowLsb + $clog2(NumBankRows);
  localparam int unsigned BankIdxW  = idx_width(NumBanks);
  localparam int unsigned RowIdxW   = idx_width(NumBankRows);
  localparam int unsigned WordIdxW  = idx_width(SramNumWords);
  localparam int unsigned PortW     = idx_width(NumPorts);

  logic [BankIdxW-1:0] p_bank [NumPorts];
  logic [RowIdxW-1:0]  p_row  [NumPorts];
  logic [WordIdxW-1:0] p_word [NumPorts];
  logic [NumPorts-1:0] p_err, credit_ok;

  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      p_bank[p] = BankIdxW'((addr_i[p] >> BankLsb) & AddrWidth'(NumBanks - 1));
      p_word[p] = WordIdxW'((addr_i[p] >> WordLsb) & AddrWidth'(SramNumWords - 1));
      p_row[p]  = RowIdxW'((addr_i[p] >> RowLsb) & AddrWidth'(NumBankRows - 1));
      p_err[p]  = |(addr_i[p] >> RangeLsb);
    end
  end

  // Round-robin per bank. The search starts at the bank's pointer. Ports with
  // no credit and out-of-range requests take no part, so they never block a
  // bank. Out-of-range requests need only credit to be granted.
  logic [NumPorts-1:0] gnt;
  logic [NumBanks-1:0] bank_hit;
  logic [PortW-1:0]    bank_win [NumBanks];
  logic [PortW-1:0]    rr_q     [NumBanks];
  logic [PortW-1:0]    rr_d     [NumBanks];

  always_comb begin
    logic [PortW-1:0] cand;
    gnt      = '0;
    bank_hit = '0;
    cand     = '0;
    for (int b = 0; b < NumBanks; b++) begin
      bank_win[b] = '0;
      rr_d[b]     = rr_q[b];
      for (int unsigned k = 0; k < NumPorts; k++) begin
        cand = PortW'((32'(rr_q[b]) + k) % NumPorts);
        if (!bank_hit[b] && req_i[cand] && !p_err[cand] && credit_ok[cand] &&
            p_bank[cand] == BankIdxW'(b)) begin
          bank_hit[b] = 1'b1;
          bank_win[b] = cand;
        end
      end
      if (bank_hit[b]) begin
        gnt[bank_win[b]] = 1'b1;
        rr_d[b]          = PortW'((32'(bank_win[b]) + 1) % NumPorts);
      end
    end
    for (int p = 0; p < NumPorts; p++) begin
      if (req_i[p] && p_err[p] && credit_ok[p]) gnt[p] = 1'b1;
    end
  end

  assign gnt_o = gnt & {NumPorts{rst_ni}};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < NumBanks; b++) rr_q[b] <= '0;
    end else begin
      for (int b = 0; b < NumBanks; b++) rr_q[b] <= rr_d[b];
    end
  end

  // Each bank sends the winner's request to the one macro that its row select names.
  logic [NumMacros-1:0]                 mac_req;
  logic                                 bank_we    [NumBanks];
  logic [WordIdxW-1:0]                  bank_word  [NumBanks];
  logic [DataWidth-1:0]                 bank_wdata [NumBanks];
  logic [NumBytes-1:0]                  bank_be    [NumBanks];
  logic [NumMacros-1:0][DataWidth-1:0]  mac_rdata;

  always_comb begin
    mac_req = '0;
    for (int b = 0; b < NumBanks; b++) begin
      bank_we[b]    = we_i[bank_win[b]];
      bank_word[b]  = p_word[bank_win[b]];
      bank_wdata[b] = wdata_i[bank_win[b]];
      bank_be[b]    = be_i[bank_win[b]];
      for (int r = 0; r < NumBankRows; r++) begin
        mac_req[b*NumBankRows+r] = rst_ni && bank_hit[b] &&
                                   (p_row[bank_win[b]] == RowIdxW'(r));
      end
    end
  end

  for (genvar b = 0; b < NumBanks; b++) begin : g_bank
    for (genvar r = 0; r < NumBankRows; r++) begin : g_row
      logic [DataWidth-1:0] mem  [SramNumWords];
      logic [DataWidth-1:0] rd_q [SramLatency];

      always_ff @(posedge clk_i) begin
        if (mac_req[b*NumBankRows+r]) begin
          if (bank_we[b]) begin
            for (int i = 0; i < NumBytes; i++) begin
              if (bank_be[b][i]) mem[bank_word[b]][i*8 +: 8] <= bank_wdata[b][i*8 +: 8];
            end
          end else begin
            rd_q[0] <= mem[bank_word[b]];
          end
        end
        for (int s = 1; s < SramLatency; s++) rd_q[s] <= rd_q[s-1];
      end

      assign mac_rdata[b*NumBankRows+r] = rd_q[SramLatency-1];
    end
  end

  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    mem_tile_sram_port_rsp #(
      .DataWidth  (DataWidth),
      .NumBanks   (NumBanks),
      .NumBankRows(NumBankRows),
      .SramLatency(SramLatency),
      .RspDepth   (RspDepth),
      .BankIdxW   (BankIdxW),
      .RowIdxW    (RowIdxW)
    ) u_rsp (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .gnt_i      (gnt_o[p]),
      .we_i       (we_i[p]),
      .err_i      (p_err[p]),
      .bank_i     (p_bank[p]),
      .row_i      (p_row[p]),
      .mac_rdata_i(mac_rdata),
      .rvalid_o   (rvalid_o[p]),
      .rready_i   (rready_i[p]),
      .rdata_o    (rdata_o[p]),
      .err_o      (err_o[p]),
      .credit_ok_o(credit_ok[p])
    );
  end

endmodule

// File: tb/tb_mem_tile_banked_sram.sv
module tb_mem_tile_banked_sram;

  localparam int SramLatency = 1;
  localparam int RspDepth    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [1:0]  gnt;
  logic        we     [2];
  logic [47:0] addr   [2];
  logic [63:0] wdata  [2];
  logic [7:0]  be     [2];
  logic        rvalid [2];
  logic        rready [2];
  logic [63:0] rdata  [2];
  logic        err    [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_tile_banked_sram dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .req_i   (req),
    .gnt_o   (gnt),
    .we_i    (we),
    .addr_i  (addr),
    .wdata_i (wdata),
    .be_i    (be),
    .rvalid_o(rvalid),
    .rready_i(rready),
    .rdata_o (rdata),
    .err_o   (err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req = '0;
    for (int p = 0; p < 2; p++) begin
      we[p] = 1'b0; addr[p] = '0; wdata[p] = '0; be[p] = '0; rready[p] = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    int          port;
    logic        we;
    logic [47:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  logic [47:0] a37 [3];
  logic [63:0] e37 [3];

  initial begin
    vecs[0]  = '{0, 1'b1, 48'h0,     64'hDEAD_BEEF_0123_4567, 8'hFF, 64'h0,                   1'b0};
    vecs[1]  = '{1, 1'b0, 48'h0,     64'h0,                   8'h00, 64'hDEAD_BEEF_0123_4567, 1'b0};
    vecs[2]  = '{1, 1'b1, 48'h8,     64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 64'h0,                   1'b0};
    vecs[3]  = '{0, 1'b1, 48'h8,     64'h1122_3344_5566_7788, 8'h0F, 64'h0,                   1'b0};
    vecs[4]  = '{1, 1'b0, 48'h8,     64'h0,                   8'h00, 64'hAAAA_AAAA_5566_7788, 1'b0};
    vecs[5]  = '{0, 1'b1, 48'h4000,  64'h0F0F_0F0F_0F0F_0F0F, 8'hFF, 64'h0,                   1'b0};
    vecs[6]  = '{0, 1'b0, 48'h4000,  64'h0,                   8'h00, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0};
    vecs[7]  = '{1, 1'b0, 48'h0,     64'h0,                   8'h00, 64'hDEAD_BEEF_0123_4567, 1'b0};
    vecs[8]  = '{0, 1'b0, 48'h10000, 64'h0,                   8'h00, 64'h0,                   1'b1};
    vecs[9]  = '{1, 1'b1, 48'h8000,  64'hCAFE_CAFE_CAFE_CAFE, 8'hFF, 64'h0,                   1'b1};
    vecs[10] = '{0, 1'b1, 48'h7FF8,  64'h1234_5678_9ABC_DEF0, 8'hFF, 64'h0,                   1'b0};
    vecs[11] = '{1, 1'b0, 48'h7FF8,  64'h0,                   8'h00, 64'h1234_5678_9ABC_DEF0, 1'b0};

    a37[0] = 48'h0;    e37[0] = 64'hDEAD_BEEF_0123_4567;
    a37[1] = 48'h8;    e37[1] = 64'hAAAA_AAAA_5566_7788;
    a37[2] = 48'h4000; e37[2] = 64'h0F0F_0F0F_0F0F_0F0F;

    // Reset state. Requests are held high to show that reset masks grants.
    idle_inputs();
    rst_n = 1'b0;
    req   = 2'b11;
    @(negedge clk);
    check("reset_gnt", gnt, 2'b00);
    check("reset_rvalid0", rvalid[0], 1'b0);
    check("reset_rvalid1", rvalid[1], 1'b0);
    check("reset_rdata0", rdata[0], 64'h0);
    check("reset_err0", err[0], 1'b0);
    req = '0;
    do_reset();

    // Single-port transactions from the vector table.
    for (int i = 0; i < NV; i++) begin
      int   p;
      int   lat;
      logic granted;
      logic got;
      p = vecs[i].port;
      idle_inputs();
      req[p]   = 1'b1;
      we[p]    = vecs[i].we;
      addr[p]  = vecs[i].addr;
      wdata[p] = vecs[i].wdata;
      be[p]    = vecs[i].be;
      granted  = 1'b0;
      for (int c = 0; c < 8 && !granted; c++) begin
        @(negedge clk);
        if (gnt[p]) begin
          granted = 1'b1;
          check($sformatf("v%0d_mac_req_count", i), $countones(dut.mac_req),
                vecs[i].exp_err ? 64'd0 : 64'd1);
        end
        next_cycle();
      end
      req = '0;
      check($sformatf("v%0d_granted", i), granted, 1'b1);
      got = 1'b0;
      lat = 1;
      while (!got && lat < 8) begin
        @(negedge clk);
        if (rvalid[p]) got = 1'b1;
        else begin
          next_cycle();
          lat++;
        end
      end
      check($sformatf("v%0d_rsp_seen", i), got, 1'b1);
      check($sformatf("v%0d_latency", i), lat, SramLatency);
      check($sformatf("v%0d_rdata", i), rdata[p], vecs[i].exp_rdata);
      check($sformatf("v%0d_err", i), err[p], vecs[i].exp_err);
      next_cycle();
    end

    // Two ports, two banks, same cycle.
    idle_inputs();
    req = 2'b11; addr[0] = 48'h0; addr[1] = 48'h8;
    @(negedge clk);
    check("dual_bank_gnt", gnt, 2'b11);
    next_cycle();
    req = '0;
    @(negedge clk);
    check("dual_bank_rvalid0", rvalid[0], 1'b1);
    check("dual_bank_rvalid1", rvalid[1], 1'b1);
    check("dual_bank_rdata0", rdata[0], 64'hDEAD_BEEF_0123_4567);
    check("dual_bank_rdata1", rdata[1], 64'hAAAA_AAAA_5566_7788);
    next_cycle();

    // Back-pressure: credits limit port 0 to RspDepth outstanding requests.
    begin
      int idx;
      int grants;
      int got;
      idle_inputs();
      rready[0] = 1'b0;
      idx = 0;
      grants = 0;
      for (int cyc = 0; cyc < 6; cyc++) begin
        req[0]  = 1'b1;
        addr[0] = a37[(idx < 3) ? idx : 2];
        @(negedge clk);
        if (gnt[0]) begin
          grants++;
          idx++;
        end
        if (cyc == 4) begin
          check("stall_rvalid_held", rvalid[0], 1'b1);
          check("stall_rdata_held", rdata[0], e37[0]);
        end
        if (cyc == 5) check("stall_gnt_blocked", gnt[0], 1'b0);
        next_cycle();
      end
      check("stall_grant_count", grants, RspDepth);
      check("stall_credit", dut.g_port[0].u_rsp.credit_q, RspDepth);
      req = '0;
      rready[0] = 1'b1;
      got = 0;
      for (int cyc = 0; cyc < 6; cyc++) begin
        @(negedge clk);
        if (rvalid[0]) begin
          if (got < 3) check($sformatf("drain%0d_rdata", got), rdata[0], e37[got]);
          got++;
        end
        next_cycle();
      end
      check("drain_count", got, RspDepth);
    end

    // Reset with two responses pending, then a request right after release.
    begin
      int idx;
      idle_inputs();
      rready[0] = 1'b0;
      idx = 0;
      for (int cyc = 0; cyc < 4; cyc++) begin
        req[0]  = 1'b1;
        addr[0] = a37[(idx < 2) ? idx : 1];
        @(negedge clk);
        if (gnt[0] && idx < 2) idx++;
        next_cycle();
      end
      check("pre_reset_pending", dut.g_port[0].u_rsp.credit_q, 2);
      rst_n   = 1'b0;
      req[0]  = 1'b1;
      addr[0] = 48'h0;
      #1;
      check("rst_mid_rvalid", rvalid[0], 1'b0);
      check("rst_mid_credit", dut.g_port[0].u_rsp.credit_q, 0);
      check("rst_mid_gnt", gnt[0], 1'b0);
      @(negedge clk);
      check("rst_mid_rvalid_next", rvalid[0], 1'b0);
      next_cycle();
      rst_n     = 1'b1;
      rready[0] = 1'b1;
      @(negedge clk);
      check("post_reset_gnt", gnt[0], 1'b1);
      next_cycle();
      req = '0;
      @(negedge clk);
      check("post_reset_rvalid", rvalid[0], 1'b1);
      next_cycle();
    end

    // Bank 0 conflict: grants alternate between ports starting at port 0.
    begin
      int cnt0;
      int cnt1;
      idle_inputs();
      do_reset();
      req = 2'b11; addr[0] = 48'h0; addr[1] = 48'h20;
      cnt0 = 0;
      cnt1 = 0;
      for (int cyc = 0; cyc < 8; cyc++) begin
        @(negedge clk);
        check($sformatf("conflict_gnt_c%0d", cyc), gnt, (cyc % 2 == 0) ? 2'b01 : 2'b10);
        if (rvalid[0]) cnt0++;
        if (rvalid[1]) cnt1++;
        next_cycle();
      end
      req = '0;
      for (int cyc = 0; cyc < 3; cyc++) begin
        @(negedge clk);
        if (rvalid[0]) cnt0++;
        if (rvalid[1]) cnt1++;
        next_cycle();
      end
      check("conflict_rsp_port0", cnt0, 4);
      check("conflict_rsp_port1", cnt1, 4);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
